// File: rtl/tc_ram_copy_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : tc_ram_copy_pkg                                                  |
// | Purpose  : Shared types and default widths for the tc_ram_copy block.       |
// |            Holds the controller state encoding and the default RAM data     |
// |            and address widths used by the top and its address generator.    |
// | Ports    : none (package)                                                   |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package tc_ram_copy_pkg;

   localparam int TC_BIT_WIDTH_DEFAULT  = 16;
   localparam int TC_ADDR_WIDTH_DEFAULT = 16;

   // Controller states, explicitly 2 bits wide.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } tc_state_e;

endpackage

`default_nettype wire

// File: rtl/tc_ram_copy_addr_gen.sv
// +----------------------------------------------------------------------------+
// | Module   : tc_ram_copy_addr_gen                                             |
// | Purpose  : base + count address generator, wrapping modulo 2^ADDR_WIDTH.    |
// |            Output is forced to zero when the port is not being used so the  |
// |            RAM address buses stay quiet between transfers.                  |
// | Ports    : en    - in,  1           : port in use this cycle                |
// |            base  - in,  ADDR_WIDTH  : latched start address                 |
// |            count - in,  ADDR_WIDTH  : word offset (low bits of counter)     |
// |            addr  - out, ADDR_WIDTH  : generated address                     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tc_ram_copy_addr_gen
   import tc_ram_copy_pkg::*;
#(
   parameter int ADDR_WIDTH = TC_ADDR_WIDTH_DEFAULT
)
(
   input  logic                  en,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH-1:0] count,
   output logic [ADDR_WIDTH-1:0] addr
);

   // Natural truncation of the sum gives the modulo-2^ADDR_WIDTH wrap.
   always_comb begin
      addr = en ? (base + count) : '0;
   end

endmodule

`default_nettype wire

// File: rtl/tc_ram_copy.sv
// +----------------------------------------------------------------------------+
// | Module   : tc_ram_copy                                                      |
// | Purpose  : Forward RAM-to-RAM block copy engine, one word per cycle.        |
// |            Reads src+i on the read port, writes dst+i on the write port     |
// |            one cycle later using the RAM read data directly.                |
// | Ports    : clk, rst_n (async, active low)                                   |
// |            start, src_addr, dst_addr, length, abort  - command inputs       |
// |            busy, done, words_written                 - status outputs       |
// |            ram_load1, ram_address1, ram_out1         - RAM read port        |
// |            ram_save, ram_address0, ram_in, ram_load0 - RAM write port       |
// | Options  : TC_RAM_COPY_FILL_EN adds fill / fill_value inputs; with fill=1   |
// |            no reads are issued and fill_value is written to every word.     |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tc_ram_copy
   import tc_ram_copy_pkg::*;
#(
   parameter int BIT_WIDTH  = TC_BIT_WIDTH_DEFAULT,
   parameter int ADDR_WIDTH = TC_ADDR_WIDTH_DEFAULT
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH-1:0] length,
`ifdef TC_RAM_COPY_FILL_EN
   input  logic                  fill,
   input  logic [BIT_WIDTH-1:0]  fill_value,
`endif
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] words_written,
   output logic                  ram_load1,
   output logic [ADDR_WIDTH-1:0] ram_address1,
   input  logic [BIT_WIDTH-1:0]  ram_out1,
   output logic                  ram_save,
   output logic [ADDR_WIDTH-1:0] ram_address0,
   output logic [BIT_WIDTH-1:0]  ram_in,
   output logic                  ram_load0
);

   // One extra counter bit so a count equal to 2^ADDR_WIDTH-1 can still be
   // compared without the counter wrapping back to zero.
   localparam int CW = ADDR_WIDTH + 1;

   tc_state_e             state_q,  state_d;
   logic [ADDR_WIDTH-1:0] src_q,    src_d;
   logic [ADDR_WIDTH-1:0] dst_q,    dst_d;
   logic [ADDR_WIDTH-1:0] len_q,    len_d;
   logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]         wr_cnt_q, wr_cnt_d;

   logic                  rd_en;
   logic                  wr_en;
   logic                  fill_mode;
   logic [BIT_WIDTH-1:0]  wr_data;
   logic [CW-1:0]         len_ext;

   assign len_ext = {1'b0, len_q};

`ifdef TC_RAM_COPY_FILL_EN
   logic                 fill_q,       fill_d;
   logic [BIT_WIDTH-1:0] fill_value_q, fill_value_d;

   assign fill_mode = fill_q;
   assign wr_data   = fill_q ? fill_value_q : ram_out1;
`else
   assign fill_mode = 1'b0;
   assign wr_data   = ram_out1;
`endif

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      rd_en    = 1'b0;
      wr_en    = 1'b0;
`ifdef TC_RAM_COPY_FILL_EN
      fill_d       = fill_q;
      fill_value_d = fill_value_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // abort is intentionally ignored here, so start+abort still launches.
            if (start) begin
               src_d    = src_addr;
               dst_d    = dst_addr;
               len_d    = length;
               rd_cnt_d = '0;
               wr_cnt_d = '0;
`ifdef TC_RAM_COPY_FILL_EN
               fill_d       = fill;
               fill_value_d = fill_value;
`endif
               state_d  = (length == '0) ? ST_FINISH : ST_RUN;
            end
         end
         ST_RUN: begin
            if (fill_mode) begin
               wr_en = (wr_cnt_q < len_ext);
            end else begin
               // Write trails read by one cycle: a write is pending whenever
               // more words have been read than written.
               rd_en = (rd_cnt_q < len_ext);
               wr_en = (wr_cnt_q < rd_cnt_q);
            end
            if (rd_en) rd_cnt_d = rd_cnt_q + CW'(1);
            if (wr_en) wr_cnt_d = wr_cnt_q + CW'(1);
            // The write presented this cycle still lands on abort.
            if (abort)
               state_d = ST_IDLE;
            else if (wr_cnt_d == len_ext)
               state_d = ST_FINISH;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
`ifdef TC_RAM_COPY_FILL_EN
         fill_q       <= 1'b0;
         fill_value_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
`ifdef TC_RAM_COPY_FILL_EN
         fill_q       <= fill_d;
         fill_value_q <= fill_value_d;
`endif
      end
   end

   tc_ram_copy_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
      .en    (rd_en),
      .base  (src_q),
      .count (rd_cnt_q[ADDR_WIDTH-1:0]),
      .addr  (ram_address1)
   );

   tc_ram_copy_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
      .en    (wr_en),
      .base  (dst_q),
      .count (wr_cnt_q[ADDR_WIDTH-1:0]),
      .addr  (ram_address0)
   );

   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_FINISH);
   assign words_written = wr_cnt_q[ADDR_WIDTH-1:0];
   assign ram_load1     = rd_en;
   assign ram_save      = wr_en;
   assign ram_in        = wr_en ? wr_data : '0;
   assign ram_load0     = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_tc_ram_copy.sv
`default_nettype none

module tb_tc_ram_copy;

   localparam int BW = 16;
   localparam int AW = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW-1:0] length   = '0;
`ifdef TC_RAM_COPY_FILL_EN
   logic          fill       = 1'b0;
   logic [BW-1:0] fill_value = '0;
`endif
   logic          busy, done, ram_load1, ram_save, ram_load0;
   logic [AW-1:0] words_written, ram_address1, ram_address0;
   logic [BW-1:0] ram_out1 = '0;
   logic [BW-1:0] ram_in;

   bit [BW-1:0] mem [0:(1<<AW)-1];

   int n_vec  = 0;
   int n_miss = 0;
   int n_load = 0;
   int n_save = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
   } wr_t;

   wr_t           wq[$];
   logic [AW-1:0] rq[$];

   typedef struct {
      logic [AW-1:0] src;
      logic [AW-1:0] dst;
      logic [AW-1:0] len;
      int            abort_at;
      bit            fill;
      logic [BW-1:0] fval;
      bit            hold_start;
      bit            abort_start;
      int            exp_lat;
      int            exp_words;
   } vec_t;

   vec_t tbl[$];

   tc_ram_copy dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .src_addr      (src_addr),
      .dst_addr      (dst_addr),
      .length        (length),
`ifdef TC_RAM_COPY_FILL_EN
      .fill          (fill),
      .fill_value    (fill_value),
`endif
      .abort         (abort),
      .busy          (busy),
      .done          (done),
      .words_written (words_written),
      .ram_load1     (ram_load1),
      .ram_address1  (ram_address1),
      .ram_out1      (ram_out1),
      .ram_save      (ram_save),
      .ram_address0  (ram_address0),
      .ram_in        (ram_in),
      .ram_load0     (ram_load0)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Synchronous read port: data appears the cycle after ram_load1.
   always @(posedge clk) begin
      if (ram_load1) ram_out1 <= mem[ram_address1];
   end

   // RAM image owner and write-port model; writes commit on the negedge,
   // and every RAM access is matched against the scoreboard queues.
   initial begin : ram_model
      logic [AW-1:0] ea;
      wr_t           ew;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i * 37 + 5);
      mem[16'h0010] = 16'hA0A0;
      mem[16'h0011] = 16'hB0B1;
      mem[16'h0012] = 16'hC0C2;
      mem[16'h0013] = 16'hD0D3;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ram_load1) begin
               n_load++;
               if (rq.size() == 0) begin
                  n_vec++; n_miss++;
                  $display("FAIL rd_addr: unexpected read of 0x%0h", ram_address1);
               end else begin
                  ea = rq.pop_front();
                  check("rd_addr", ram_address1, ea);
               end
            end
            if (ram_save) begin
               n_save++;
               mem[ram_address0] = ram_in;
               if (wq.size() == 0) begin
                  n_vec++; n_miss++;
                  $display("FAIL wr: unexpected write of 0x%0h to 0x%0h", ram_in, ram_address0);
               end else begin
                  ew = wq.pop_front();
                  check("wr_addr", ram_address0, ew.addr);
                  check("wr_data", ram_in, ew.data);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected accesses for a transfer, derived from the RAM image before it starts.
   task automatic prep(input vec_t v, output logic [BW-1:0] expd[$]);
      logic [AW-1:0] s, d;
      logic [BW-1:0] x;
      expd.delete();
      for (int i = 0; i < int'(v.len); i++) begin
         s = v.src + AW'(i);
         d = v.dst + AW'(i);
         x = v.fill ? v.fval : mem[s];
         expd.push_back(x);
         wq.push_back('{addr: d, data: x});
         if (!v.fill) rq.push_back(s);
      end
   endtask

   task automatic drive_start(input vec_t v);
      src_addr = v.src;
      dst_addr = v.dst;
      length   = v.len;
      start    = 1'b1;
      abort    = v.abort_start;
`ifdef TC_RAM_COPY_FILL_EN
      fill       = v.fill;
      fill_value = v.fval;
`endif
   endtask

   task automatic scramble_args(input vec_t v);
      src_addr = ~v.src;
      dst_addr = ~v.dst;
      length   = 16'h0007;
      abort    = 1'b0;
      start    = v.hold_start;
`ifdef TC_RAM_COPY_FILL_EN
      fill       = 1'b0;
      fill_value = 16'h1234;
`endif
   endtask

   task automatic run_vec(input vec_t v);
      logic [BW-1:0] expd[$];
      logic [AW-1:0] d;
      int            c;
      bit            saw_done;
      n_load = 0;
      n_save = 0;
      check("idle_busy", busy, 0);
      prep(v, expd);
      drive_start(v);
      tick();
      c = 1;
      scramble_args(v);
      check("run_busy", busy, 1);
      if (v.abort_at >= 0) begin
         while (c < v.abort_at + 1) begin tick(); c++; end
         abort = 1'b1;
         tick();
         abort = 1'b0;
         start = 1'b0;
         check("abort_busy", busy, 0);
         check("abort_done", done, 0);
         check("abort_words", words_written, v.exp_words);
         check("abort_wq_left", wq.size(), int'(v.len) - v.exp_words);
         check("abort_loads", n_load, v.abort_at + 1);
         check("abort_saves", n_save, v.exp_words);
         wq.delete();
         rq.delete();
         saw_done = 1'b0;
         for (int k = 0; k < 4; k++) begin
            tick();
            if (done) saw_done = 1'b1;
         end
         check("abort_no_done", saw_done, 0);
      end else begin
         while (!done && c < 200) begin tick(); c++; end
         start = 1'b0;
         check("done_lat", c, v.exp_lat);
         check("done_busy", busy, 1);
         check("words", words_written, v.exp_words);
         tick();
         check("done_pulse", done, 0);
         check("busy_after", busy, 0);
         check("wq_empty", wq.size(), 0);
         check("rq_empty", rq.size(), 0);
         check("loads", n_load, v.fill ? 0 : int'(v.len));
         check("saves", n_save, int'(v.len));
         for (int i = 0; i < int'(v.len); i++) begin
            d = v.dst + AW'(i);
            check("mem", mem[d], expd[i]);
         end
         wq.delete();
         rq.delete();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_words"}, words_written, 0);
      check({tag, "_load1"}, ram_load1, 0);
      check({tag, "_save"}, ram_save, 0);
      check({tag, "_addr0"}, ram_address0, 0);
      check({tag, "_addr1"}, ram_address1, 0);
      check({tag, "_ram_in"}, ram_in, 0);
      check({tag, "_load0"}, ram_load0, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t          rv;
      logic [BW-1:0] dummy[$];
      //                 basic copy, len 0, address wrap, abort, start+abort, start held busy, overlap dst<src
      tbl.push_back('{src:16'h0010, dst:16'h0040, len:16'd4, abort_at:-1, fill:1'b0, fval:16'h0,
                      hold_start:1'b0, abort_start:1'b0, exp_lat:6, exp_words:4});
      tbl.push_back('{src:16'h0123, dst:16'h0456, len:16'd0, abort_at:-1, fill:1'b0, fval:16'h0,
                      hold_start:1'b0, abort_start:1'b0, exp_lat:1, exp_words:0});
      tbl.push_back('{src:16'hFFFE, dst:16'h0100, len:16'd4, abort_at:-1, fill:1'b0, fval:16'h0,
                      hold_start:1'b0, abort_start:1'b0, exp_lat:6, exp_words:4});
      tbl.push_back('{src:16'h0200, dst:16'h0300, len:16'd8, abort_at:2, fill:1'b0, fval:16'h0,
                      hold_start:1'b0, abort_start:1'b0, exp_lat:0, exp_words:2});
      tbl.push_back('{src:16'h0050, dst:16'h0060, len:16'd1, abort_at:-1, fill:1'b0, fval:16'h0,
                      hold_start:1'b0, abort_start:1'b1, exp_lat:3, exp_words:1});
      tbl.push_back('{src:16'h0090, dst:16'h00A0, len:16'd4, abort_at:-1, fill:1'b0, fval:16'h0,
                      hold_start:1'b1, abort_start:1'b0, exp_lat:6, exp_words:4});
      tbl.push_back('{src:16'h0081, dst:16'h0080, len:16'd5, abort_at:-1, fill:1'b0, fval:16'h0,
                      hold_start:1'b0, abort_start:1'b0, exp_lat:7, exp_words:5});
`ifdef TC_RAM_COPY_FILL_EN
      tbl.push_back('{src:16'h0700, dst:16'h0020, len:16'd3, abort_at:-1, fill:1'b1, fval:16'hBEEF,
                      hold_start:1'b0, abort_start:1'b0, exp_lat:4, exp_words:3});
`endif

      // Power-on reset state.
      #12;
      check_all_zero("por");
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i]);
         tick();
      end

      // Reset in the middle of a copy: outputs clear without waiting for a clock.
      rv = '{src:16'h0400, dst:16'h0500, len:16'd8, abort_at:-1, fill:1'b0, fval:16'h0,
             hold_start:1'b0, abort_start:1'b0, exp_lat:10, exp_words:8};
      prep(rv, dummy);
      drive_start(rv);
      tick();
      scramble_args(rv);
      tick();
      tick();
      check("mid_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst");
      wq.delete();
      rq.delete();
      @(posedge clk); #1;
      check("rst_hold_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // A fresh copy after the reset behaves normally.
      rv.src = 16'h0010;
      rv.dst = 16'h0600;
      rv.len = 16'd4;
      rv.exp_lat = 6;
      rv.exp_words = 4;
      run_vec(rv);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

`default_nettype wire
